// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam int ARB_MAX_N = 16;

    // Index width for n requesters, never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotating-priority encoder: first set bit of req at or above ptr,
// wrapping from N-1 back to 0.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_vld
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;

    function automatic int wrap_idx(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    // Rotating the doubled vector puts the highest-priority requester at bit 0.
    always_comb begin
        req_dbl = {req, req};
        req_rot = N'(req_dbl >> ptr);
        gnt_id  = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_vld && req_rot[k]) begin
                gnt_vld = 1'b1;
                gnt_id  = IW'(wrap_idx(int'(ptr) + k));
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter driving the async FIFO write port.
// Optional per-requester beat counters are enabled by FIFO_WR_ARB_CNT_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 16
`ifdef FIFO_WR_ARB_CNT_EN
    , parameter int CNTW = 16
`endif
    , localparam int IW = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    input  logic            wfull,
    output logic            winc,
    output logic [DW-1:0]   wdata,
    output logic [IW-1:0]   grant_id,
    output logic            busy
`ifdef FIFO_WR_ARB_CNT_EN
    , input  logic [IW-1:0]   cnt_sel,
    input  logic              cnt_clr,
    output logic [CNTW-1:0]   cnt_val
`endif
);

    arb_state_t    state, state_d;
    logic [IW-1:0] owner, owner_d;
    logic [IW-1:0] rr_ptr, rr_ptr_d;
    logic [IW-1:0] pick_id;
    logic          pick_vld;
    logic [IW-1:0] gnt;
    logic          gnt_vld;
    logic          sel_valid;
    logic          sel_last;

    fifo_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_id  (pick_id),
        .gnt_vld (pick_vld)
    );

    // Handshake: a beat moves when req_valid[g] & req_ready[g]; req_ready is
    // !wfull for the grantee only, so winc is exactly that product.
    always_comb begin
        gnt       = (state == ARB_LOCK) ? owner : pick_id;
        gnt_vld   = rst_n && ((state == ARB_LOCK) || pick_vld);
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        wdata     = '0;
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_vld && (gnt == IW'(i))) begin
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                wdata        = req_data[i*DW +: DW];
                req_ready[i] = !wfull;
            end
        end
        winc     = sel_valid && !wfull;
        grant_id = gnt_vld ? gnt : '0;
    end

    always_comb begin
        state_d  = state;
        owner_d  = owner;
        rr_ptr_d = rr_ptr;
        if (winc) begin
            if (sel_last) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = (gnt == IW'(N - 1)) ? '0 : gnt + IW'(1);
            end else if (state == ARB_IDLE) begin
                state_d = ARB_LOCK;
                owner_d = gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_d;
            owner  <= owner_d;
            rr_ptr <= rr_ptr_d;
        end
    end

    assign busy = (state == ARB_LOCK);

`ifdef FIFO_WR_ARB_CNT_EN
    logic [CNTW-1:0] cnt [N];

    // Clear takes priority over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (winc && (gnt == IW'(i)) && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + CNTW'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_val = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_sel == IW'(i)) cnt_val = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter (N=4) plus a directed N=3 wrap check.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    typedef struct packed {
        logic          winc;
        logic [IW-1:0] gid;
        logic [N-1:0]  rdy;
        logic          busy;
        logic [DW-1:0] data;
        logic [3:0]    cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            wfull, winc, busy;
    logic [DW-1:0]   wdata;
    logic [IW-1:0]   grant_id;
    logic [IW-1:0]   cnt_sel;
    logic            cnt_clr;
`ifdef FIFO_WR_ARB_CNT_EN
    logic [3:0]      cnt_val;
`endif

    logic            r3_rst_n;
    logic [2:0]      r3_valid, r3_last, r3_ready;
    logic [3*DW-1:0] r3_data;
    logic            r3_winc, r3_busy;
    logic [DW-1:0]   r3_wdata;
    logic [1:0]      r3_gid;
`ifdef FIFO_WR_ARB_CNT_EN
    logic [3:0]      r3_cnt_val;
`endif

    fifo_wr_arbiter #(.N(N), .DW(DW)
`ifdef FIFO_WR_ARB_CNT_EN
        , .CNTW(4)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
        .wdata(wdata), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARB_CNT_EN
        , .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_val(cnt_val)
`endif
    );

    fifo_wr_arbiter #(.N(3), .DW(DW)
`ifdef FIFO_WR_ARB_CNT_EN
        , .CNTW(4)
`endif
    ) dut3 (
        .clk(clk), .rst_n(r3_rst_n), .req_valid(r3_valid), .req_data(r3_data),
        .req_last(r3_last), .req_ready(r3_ready), .wfull(1'b0), .winc(r3_winc),
        .wdata(r3_wdata), .grant_id(r3_gid), .busy(r3_busy)
`ifdef FIFO_WR_ARB_CNT_EN
        , .cnt_sel(2'd0), .cnt_clr(1'b0), .cnt_val(r3_cnt_val)
`endif
    );

    // Scoreboard state
    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Producer beat stores: {last, data}, ring-indexed by 8-bit head/tail
    logic [DW:0]   beats [N][256];
    logic [7:0]    head [N];
    logic [7:0]    tail [N];
    logic [N-1:0]  hold;
    logic [N-1:0]  pres;

    // Reference model state
    bit m_lock;
    int m_owner;
    int m_ptr;
    int m_cnt [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int i, input int len);
        logic [DW-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = {4'(i), 12'($urandom_range(0, 4095))};
            beats[i][tail[i]] = {(b == len - 1), d};
            tail[i] = tail[i] + 8'd1;
        end
    endtask

    // Drive one cycle of stimulus and push the model's expected outputs.
    task automatic step(input logic rst, input logic full, input logic [N-1:0] want,
                        input logic clr, input logic [IW-1:0] sel);
        exp_t e;
        int   g;
        logic lst;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            pres[i] = hold[i] || (want[i] && (head[i] != tail[i]));
        rst_n     = rst;
        wfull     = full;
        req_valid = pres;
        cnt_clr   = clr;
        cnt_sel   = sel;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = pres[i] ? beats[i][head[i]][DW-1:0] : DW'($urandom);
            req_last[i]          = pres[i] ? beats[i][head[i]][DW] : 1'($urandom);
        end
        e = '0;
        if (!rst) begin
            m_lock = 0; m_owner = 0; m_ptr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            hold = '0;
        end else begin
            g = -1;
            if (m_lock) g = m_owner;
            else
                for (int k = 0; k < N; k++)
                    if (g < 0 && pres[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            e.busy = m_lock;
            e.cnt  = 4'(m_cnt[sel]);
            lst    = 1'b0;
            if (g >= 0) begin
                e.gid    = IW'(g);
                e.rdy[g] = !full;
                e.winc   = pres[g] && !full;
            end
            hold = pres;
            if (e.winc) begin
                e.data  = beats[g][head[g]][DW-1:0];
                lst     = beats[g][head[g]][DW];
                head[g] = head[g] + 8'd1;
                hold[g] = 1'b0;
            end
            if (clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
            else if (e.winc && m_cnt[g] < 15) m_cnt[g]++;
            if (e.winc) begin
                if (lst) begin
                    m_lock = 0;
                    m_ptr  = (g + 1) % N;
                end else if (!m_lock) begin
                    m_lock  = 1;
                    m_owner = g;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs each cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("winc", 32'(winc), 32'(e.winc));
                chk("grant_id", 32'(grant_id), 32'(e.gid));
                chk("req_ready", 32'(req_ready), 32'(e.rdy));
                chk("busy", 32'(busy), 32'(e.busy));
                if (e.winc) chk("wdata", 32'(wdata), 32'(e.data));
`ifdef FIFO_WR_ARB_CNT_EN
                chk("cnt_val", 32'(cnt_val), 32'(e.cnt));
`endif
            end
        end
    end

    task automatic r3_cycle(input logic [2:0] v, input logic [2:0] l, input int exp_gid,
                            input logic exp_winc, input logic exp_busy);
        @(posedge clk);
        #1;
        r3_rst_n = 1'b1;
        r3_valid = v;
        r3_last  = l;
        @(negedge clk);
        chk("n3_grant_id", 32'(r3_gid), 32'(exp_gid));
        chk("n3_winc", 32'(r3_winc), 32'(exp_winc));
        chk("n3_busy", 32'(r3_busy), 32'(exp_busy));
        if (exp_winc) chk("n3_wdata", 32'(r3_wdata), 32'(16'h00a0 + 16'(exp_gid)));
    endtask

    initial begin
        rst_n = 1'b0; wfull = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
        cnt_sel = '0; cnt_clr = 1'b0; hold = '0; pres = '0;
        r3_rst_n = 1'b0; r3_valid = '0; r3_last = '0;
        r3_data = {16'h00a2, 16'h00a1, 16'h00a0};
        m_lock = 0; m_owner = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            head[i] = '0; tail[i] = '0; m_cnt[i] = 0;
        end

        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 4'h0, 1'b0, 2'd0);

        // Round-robin over single-beat packets
        for (int i = 0; i < N; i++) begin add_pkt(i, 1); add_pkt(i, 1); end
        for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 4'hF, 1'b0, 2'd0);

        // Packet lock with a bubble while neighbours are valid
        add_pkt(0, 1);
        step(1'b1, 1'b0, 4'b0001, 1'b0, 2'd1);
        add_pkt(1, 3); add_pkt(0, 1); add_pkt(2, 1);
        step(1'b1, 1'b0, 4'b0111, 1'b0, 2'd1);
        step(1'b1, 1'b0, 4'b0101, 1'b0, 2'd1);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 4'b0111, 1'b0, 2'd1);

        // Full stall mid-packet
        add_pkt(3, 4);
        for (int c = 0; c < 2; c++) step(1'b1, 1'b0, 4'b1000, 1'b0, 2'd3);
        for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 4'b1000, 1'b0, 2'd3);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 4'b1000, 1'b0, 2'd3);

        // Reset during beat 2 of 4
        add_pkt(2, 4);
        step(1'b1, 1'b0, 4'b0100, 1'b0, 2'd2);
        step(1'b0, 1'b0, 4'b0100, 1'b0, 2'd2);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 2'd2);
        add_pkt(0, 1);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 4'b0101, 1'b0, 2'd0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if (8'(tail[i] - head[i]) < 8'd4 && $urandom_range(0, 3) == 0)
                    add_pkt(i, $urandom_range(1, 5));
            step(($urandom_range(0, 149) != 0), ($urandom_range(0, 4) == 0),
                 4'($urandom), ($urandom_range(0, 31) == 0), 2'($urandom));
        end

        // Saturation and clear-wins on requester 3
        step(1'b0, 1'b0, 4'h0, 1'b0, 2'd3);
        step(1'b0, 1'b0, 4'h0, 1'b0, 2'd3);
        head[3] = tail[3];
        for (int c = 0; c < 20; c++) add_pkt(3, 1);
        for (int c = 0; c < 18; c++) step(1'b1, 1'b0, 4'b1000, 1'b0, 2'd3);
        step(1'b1, 1'b0, 4'b1000, 1'b1, 2'd3);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 4'b0000, 1'b0, 2'd3);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // N=3 wrap: 1 -> ptr 2; then 2 before 0; ptr back to 1; then a lock on 2
        r3_cycle(3'b010, 3'b111, 1, 1'b1, 1'b0);
        r3_cycle(3'b101, 3'b111, 2, 1'b1, 1'b0);
        r3_cycle(3'b001, 3'b111, 0, 1'b1, 1'b0);
        r3_cycle(3'b111, 3'b111, 1, 1'b1, 1'b0);
        r3_cycle(3'b101, 3'b000, 2, 1'b1, 1'b0);
        r3_cycle(3'b001, 3'b000, 2, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
